// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: ROM port, redirect input and decode handshake of the fetch sequencer.
interface ifetch_ctrl_if #(parameter int ADDR_W = 7) ();
    logic [ADDR_W-1:0] rom_address;
    logic              rom_en;
    logic [31:0]       rom_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [31:0]       inst_out;
    logic [ADDR_W-1:0] inst_pc;
    modport master (
        output rom_address, rom_en, inst_valid, inst_out, inst_pc,
        input  rom_data, redirect_valid, redirect_pc, inst_ready
    );
    modport slave (
        input  rom_address, rom_en, inst_valid, inst_out, inst_pc,
        output rom_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer with one-entry output buffer, redirects, end-of-ROM halt and fault.
module ifetch_ctrl #(
    parameter int ADDR_W    = 7,
    parameter int ROM_BYTES = 128,
    parameter int RESET_PC  = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    ifetch_ctrl_if.master    bus,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;
    localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(ROM_BYTES - 4);
    // One extra PC bit so stepping past the last word never aliases back to address 0.
    logic [1:0]        state;
    logic [ADDR_W:0]   pc_q;
    logic              valid_q;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] ipc_q;
    logic              redir;
    logic              past_end;
    logic              accept;
    logic              fetch;
    assign redir    = (state == S_RUN || state == S_DONE) && bus.redirect_valid;
    assign past_end = pc_q > LAST;
    assign accept   = bus.inst_valid & bus.inst_ready;
    assign fetch    = state == S_RUN && !past_end && !redir && (!valid_q || bus.inst_ready);
    assign bus.rom_address = pc_q[ADDR_W-1:0];
    assign bus.rom_en      = state == S_RUN && !past_end;
    assign bus.inst_valid  = valid_q && state != S_FAULT;
    assign bus.inst_out    = data_q;
    assign bus.inst_pc     = ipc_q;
    assign done  = state == S_DONE;
    assign fault = state == S_FAULT;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc_q        <= (ADDR_W+1)'(RESET_PC);
            valid_q     <= 1'b0;
            data_q      <= '0;
            ipc_q       <= '0;
            fetch_count <= '0;
        end else begin
            if (accept && !redir && fetch_count != '1)
                fetch_count <= fetch_count + 1'b1;
            if (redir) begin
                valid_q <= 1'b0;
                if (bus.redirect_pc[1:0] != 2'b00) begin
                    state <= S_FAULT;
                end else begin
                    pc_q  <= {1'b0, bus.redirect_pc};
                    state <= ({1'b0, bus.redirect_pc} > LAST) ? S_DONE : S_RUN;
                end
            end else if (fetch) begin
                data_q  <= bus.rom_data;
                ipc_q   <= pc_q[ADDR_W-1:0];
                valid_q <= 1'b1;
                pc_q    <= pc_q + (ADDR_W+1)'(4);
            end else begin
                if (accept)
                    valid_q <= 1'b0;
                if (state == S_IDLE && start)
                    state <= S_RUN;
                if (state == S_RUN && past_end)
                    state <= S_DONE;
            end
        end
    end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed stimulus with a scoreboard of expected deliveries checked by a monitor.
module tb_ifetch_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        done;
    logic        fault;
    logic [15:0] fetch_count;
    int          checks = 0;
    int          errors = 0;
    int          exp_q[$];

    ifetch_ctrl_if #(.ADDR_W(7)) bus ();

    ifetch_ctrl #(.ADDR_W(7), .ROM_BYTES(128), .RESET_PC(0), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bus(bus),
        .done(done),
        .fault(fault),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [6:0] a);
        return {8'hA5, 1'b0, a, 8'h3C ^ {1'b0, a}, ~{1'b0, a}};
    endfunction

    assign bus.rom_data = rom_word(bus.rom_address);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every accepted word that is not flushed by a redirect must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deliver: got pc=%0d with empty scoreboard", bus.inst_pc);
            end else begin
                automatic int e = exp_q.pop_front();
                if (bus.inst_pc !== 7'(e) || bus.inst_out !== rom_word(7'(e))) begin
                    errors++;
                    $display("FAIL deliver: got pc=%0d data=%h expected pc=%0d data=%h",
                             bus.inst_pc, bus.inst_out, e, rom_word(7'(e)));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; start = 0;
        bus.inst_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
        tick(); tick(); rst = 0;
        chk("rst_valid", 32'(bus.inst_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_count", 32'(fetch_count), 0);
        chk("rst_rom_en", 32'(bus.rom_en), 0);
        chk("rst_addr", 32'(bus.rom_address), 0);
        bus.redirect_valid = 1; bus.redirect_pc = 8;
        tick(); bus.redirect_valid = 0;
        chk("idle_redir_addr", 32'(bus.rom_address), 0);
        chk("idle_redir_en", 32'(bus.rom_en), 0);
        // Full sweep at full throughput.
        for (int p = 0; p < 128; p += 4) exp_q.push_back(p);
        bus.inst_ready = 1; start = 1;
        tick(); start = 0;
        chk("run_rom_en", 32'(bus.rom_en), 1);
        repeat (32) tick();
        chk("last_pc", 32'(bus.inst_pc), 124);
        chk("last_valid", 32'(bus.inst_valid), 1);
        chk("last_not_done", 32'(done), 0);
        tick();
        chk("done_set", 32'(done), 1);
        chk("done_drained", 32'(bus.inst_valid), 0);
        chk("done_count", 32'(fetch_count), 32);
        chk("done_rom_en", 32'(bus.rom_en), 0);
        // Redirect out of DONE, then stall on the PC-8 word.
        exp_q.push_back(8); exp_q.push_back(12);
        bus.redirect_valid = 1; bus.redirect_pc = 8; bus.inst_ready = 0;
        tick(); bus.redirect_valid = 0;
        chk("redir_done_clear", 32'(done), 0);
        chk("redir_done_valid", 32'(bus.inst_valid), 0);
        chk("redir_done_addr", 32'(bus.rom_address), 8);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i != 0) tick();
            chk("stall_pc", 32'(bus.inst_pc), 8);
            chk("stall_data", bus.inst_out, rom_word(7'd8));
            chk("stall_addr", 32'(bus.rom_address), 12);
            chk("stall_rom_en", 32'(bus.rom_en), 1);
        end
        bus.inst_ready = 1;
        tick();
        chk("no_gap_pc", 32'(bus.inst_pc), 12);
        chk("no_gap_count", 32'(fetch_count), 33);
        tick();
        chk("pre_redir_pc", 32'(bus.inst_pc), 16);
        // Redirect drops the PC-16 word even though decode is ready.
        bus.redirect_valid = 1; bus.redirect_pc = 4;
        tick(); bus.redirect_valid = 0;
        chk("flush_valid", 32'(bus.inst_valid), 0);
        chk("flush_count", 32'(fetch_count), 34);
        chk("flush_addr", 32'(bus.rom_address), 4);
        for (int p = 4; p <= 16; p += 4) exp_q.push_back(p);
        tick();
        chk("target_pc", 32'(bus.inst_pc), 4);
        chk("target_valid", 32'(bus.inst_valid), 1);
        repeat (4) tick();
        chk("mid_pc", 32'(bus.inst_pc), 20);
        rst = 1; bus.inst_ready = 0;
        tick(); rst = 0;
        chk("midrst_valid", 32'(bus.inst_valid), 0);
        chk("midrst_count", 32'(fetch_count), 0);
        chk("midrst_addr", 32'(bus.rom_address), 0);
        chk("midrst_rom_en", 32'(bus.rom_en), 0);
        chk("midrst_done", 32'(done), 0);
        // Misaligned redirect faults; only reset leaves FAULT.
        start = 1; tick(); start = 0;
        bus.redirect_valid = 1; bus.redirect_pc = 6;
        tick(); bus.redirect_valid = 0;
        chk("fault_set", 32'(fault), 1);
        chk("fault_rom_en", 32'(bus.rom_en), 0);
        chk("fault_valid", 32'(bus.inst_valid), 0);
        start = 1; bus.redirect_valid = 1; bus.redirect_pc = 8;
        tick(); start = 0; bus.redirect_valid = 0;
        chk("fault_hold", 32'(fault), 1);
        chk("fault_hold_en", 32'(bus.rom_en), 0);
        chk("fault_pc_kept", 32'(bus.rom_address), 0);
        rst = 1; tick(); rst = 0;
        chk("fault_rst", 32'(fault), 0);
        chk("fault_rst_addr", 32'(bus.rom_address), 0);
        chk("fault_rst_en", 32'(bus.rom_en), 0);
        // Redirect to the last word, deliver it, then DONE; misaligned redirect from DONE faults.
        start = 1; tick(); start = 0;
        bus.redirect_valid = 1; bus.redirect_pc = 7'h7C; bus.inst_ready = 1;
        tick(); bus.redirect_valid = 0;
        chk("last_redir_addr", 32'(bus.rom_address), 32'h7C);
        exp_q.push_back(32'h7C);
        tick();
        chk("last_word_pc", 32'(bus.inst_pc), 32'h7C);
        chk("last_word_not_done", 32'(done), 0);
        tick();
        chk("last_word_done", 32'(done), 1);
        chk("last_word_count", 32'(fetch_count), 1);
        bus.redirect_valid = 1; bus.redirect_pc = 7'h7E;
        tick(); bus.redirect_valid = 0;
        chk("done_mis_fault", 32'(fault), 1);
        chk("done_mis_done", 32'(done), 0);
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
